rot_arbiter: RTL and testbench



---
 rtl/rot_pkg.sv | 16 +
 rtl/multiFun_barrelShifter.sv | 28 ++
 rtl/rot_arbiter.sv | 109 ++++++++++
 tb/tb_rot_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared types and constants for the rotate arbiter slice.
package rot_pkg;

  localparam int unsigned ROT_W = 8;
  localparam int unsigned AMT_W = 3;

  localparam logic ROT_RIGHT = 1'b1;
  localparam logic ROT_LEFT  = 1'b0;

  typedef struct packed {
    logic [ROT_W-1:0] num;
    logic [AMT_W-1:0] amt;
    logic             lr;
  } rot_cmd_t;

endpackage

// File: rtl/multiFun_barrelShifter.sv
// Combinational 8-bit circular rotator; lr=1 rotates right, lr=0 rotates left.
module multiFun_barrelShifter
  import rot_pkg::*;
(
  input  logic [ROT_W-1:0] num,
  input  logic [AMT_W-1:0] amt,
  input  logic             lr,
  output logic [ROT_W-1:0] res
);

  logic [2*ROT_W-1:0] dbl;
  logic [AMT_W:0]     rsel;
  logic [AMT_W:0]     lsel;

  // Rotation is a window into the operand concatenated with itself.
  assign dbl  = {num, num};
  assign rsel = {1'b0, amt};
  assign lsel = (AMT_W + 1)'(ROT_W) - {1'b0, amt};

  always_comb begin
    res = num;
    case (lr)
      ROT_RIGHT: res = dbl[rsel +: ROT_W];
      ROT_LEFT:  res = dbl[lsel +: ROT_W];
    endcase
  end

endmodule

// File: rtl/rot_arbiter.sv
// Round-robin arbiter sharing one rotator among NREQ requesters, with a single
// registered, tagged output stage.
module rot_arbiter
  import rot_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*ROT_W-1:0] req_num,
  input  logic [NREQ*AMT_W-1:0] req_amt,
  input  logic [NREQ-1:0]       req_lr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ROT_W-1:0]      out_data,
  output logic [IDW-1:0]        out_id
);

  // Returns {found, index} of the first valid requester at or after ptr.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  ptr);
    logic [IDW:0] pick;
    int unsigned  idx;
    pick = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!pick[IDW] && valid[idx[IDW-1:0]]) begin
        pick = {1'b1, idx[IDW-1:0]};
      end
    end
    return pick;
  endfunction

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gnt;
  logic             found;
  logic             can_accept;
  logic             accept;
  rot_cmd_t         cmd;
  logic [ROT_W-1:0] rot_res;

  logic             out_valid_q;
  logic [ROT_W-1:0] out_data_q;
  logic [IDW-1:0]   out_id_q;

  assign can_accept   = !out_valid_q || out_ready;
  assign {found, gnt} = rr_pick(req_valid, ptr_q);

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = found && (IDW'(i) == gnt) && can_accept && !rst;
    end
  end

  assign accept = |req_ready;

  always_comb begin
    cmd = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == gnt) begin
        cmd.num = req_num[i*ROT_W +: ROT_W];
        cmd.amt = req_amt[i*AMT_W +: AMT_W];
        cmd.lr  = req_lr[i];
      end
    end
  end

  // Only real transfers move the pointer; idle cycles keep fairness state.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = IDW'((32'(gnt) + 1) % NREQ);
    end
  end

  multiFun_barrelShifter u_rot (
    .num (cmd.num),
    .amt (cmd.amt),
    .lr  (cmd.lr),
    .res (rot_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= rot_res;
        out_id_q    <= gnt;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_rot_arbiter.sv
// Self-checking bench for rot_arbiter against a cycle-level behavioural model.
module tb_rot_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready, req_lr;
  logic [NREQ*8-1:0] req_num;
  logic [NREQ*3-1:0] req_amt;
  logic              out_valid, out_ready;
  logic [7:0]        out_data;
  logic [IDW-1:0]    out_id;

  int checks   = 0;
  int failures = 0;

  // Model state
  int         m_ptr  = 0;
  bit         m_ov   = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         m_id   = 0;

  always #5 clk = ~clk;

  rot_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_num   (req_num),
    .req_amt   (req_amt),
    .req_lr    (req_lr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  function automatic logic [7:0] rot_ref(input logic [7:0] n, input int a, input bit right);
    int v;
    int r;
    v = int'(n);
    if (right) r = (v >> a) | (v << (8 - a));
    else       r = (v << a) | (v >> (8 - a));
    return r[7:0];
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] r;
    r = '0;
    if (rst || (m_ov && !out_ready)) return r;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  task automatic tick();
    logic [NREQ-1:0] g;
    g = exp_ready();
    @(posedge clk);
    if (rst) begin
      m_ov = 1'b0; m_data = 8'h00; m_id = 0; m_ptr = 0;
    end else if (g != '0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (g[i]) begin
          m_data = rot_ref(req_num[8*i +: 8], int'(req_amt[3*i +: 3]), req_lr[i]);
          m_id   = i;
          m_ov   = 1'b1;
          m_ptr  = (i + 1) % NREQ;
        end
      end
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    #1;
  endtask

  task automatic set_cmd(input int i, input logic [7:0] n, input int a, input bit lr);
    logic [2:0] a3;
    a3 = a[2:0];
    req_num[8*i +: 8] = n;
    req_amt[3*i +: 3] = a3;
    req_lr[i]         = lr;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; out_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b want=00", req_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_id !== 1'b0) begin
      failures++;
      $display("FAIL reset_out got v=%b d=%h id=%0d want v=0 d=00 id=0", out_valid, out_data, out_id);
    end
    tick();
    rst = 1'b0; req_valid = '0;
    tick();
  endtask

  task automatic test_directed();
    int         ids[4]  = '{0, 1, 1, 1};
    logic [7:0] nums[4] = '{8'h81, 8'h96, 8'h96, 8'h96};
    int         amts[4] = '{1, 3, 3, 0};
    bit         lrs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] lits[4] = '{8'hC0, 8'hB4, 8'hD2, 8'h96};
    for (int t = 0; t < 4; t++) begin
      logic [NREQ-1:0] want;
      want = '0; want[ids[t]] = 1'b1;
      req_valid = want; out_ready = 1'b1;
      set_cmd(ids[t], nums[t], amts[t], lrs[t]);
      @(negedge clk);
      checks++;
      if (req_ready !== want) begin
        failures++; $display("FAIL dir_ready[%0d] got=%b want=%b", t, req_ready, want);
      end
      tick();
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== lits[t] || out_data !== m_data
          || out_id !== IDW'(ids[t])) begin
        failures++;
        $display("FAIL dir_out[%0d] got v=%b d=%h id=%0d want v=1 d=%h id=%0d",
                 t, out_valid, out_data, out_id, lits[t], ids[t]);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    req_valid = '1; out_ready = 1'b1;
    set_cmd(0, 8'h12, 2, 1'b0);
    set_cmd(1, 8'hF0, 4, 1'b1);
    for (int c = 0; c < 6; c++) begin
      logic [NREQ-1:0] want;
      want = '0; want[c % 2] = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== want || !$onehot(req_ready) || req_ready !== exp_ready()) begin
        failures++; $display("FAIL rr_grant[%0d] got=%b want=%b", c, req_ready, want);
      end
      checks++;
      if (c > 0 && (out_data !== m_data || out_id !== IDW'(m_id))) begin
        failures++;
        $display("FAIL rr_out[%0d] got d=%h id=%0d want d=%h id=%0d", c, out_data, out_id, m_data, m_id);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held_d;
    int         held_i;
    logic [NREQ-1:0] want;
    req_valid = '1; out_ready = 1'b1;
    @(negedge clk);
    tick();
    held_d = m_data; held_i = m_id;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b00) begin
        failures++; $display("FAIL bp_ready[%0d] got=%b want=00", c, req_ready);
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== held_d || out_id !== IDW'(held_i)) begin
        failures++;
        $display("FAIL bp_hold[%0d] got v=%b d=%h id=%0d want v=1 d=%h id=%0d",
                 c, out_valid, out_data, out_id, held_d, held_i);
      end
      tick();
    end
    out_ready = 1'b1;
    want = '0; want[(held_i + 1) % NREQ] = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== want) begin
      failures++; $display("FAIL bp_resume got=%b want=%b", req_ready, want);
    end
    tick();
    req_valid = '0;
    tick();
  endtask

  task automatic test_drain();
    logic [7:0] held_d;
    req_valid = 2'b01; out_ready = 1'b1;
    set_cmd(0, 8'h3C, 2, 1'b0);
    @(negedge clk);
    tick();
    req_valid = '0;
    held_d = rot_ref(8'h3C, 2, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== held_d) begin
      failures++; $display("FAIL drain_pre got v=%b d=%h want v=1 d=%h", out_valid, out_data, held_d);
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== held_d) begin
      failures++; $display("FAIL drain_empty got v=%b d=%h want v=0 d=%h", out_valid, out_data, held_d);
    end
    tick();
    req_valid = 2'b01;
    tick();
    req_valid = 2'b10;
    set_cmd(1, 8'h5A, 5, 1'b1);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin
      failures++; $display("FAIL drain_refill_ready got=%b want=10", req_ready);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== rot_ref(8'h5A, 5, 1'b1) || out_id !== 1'b1) begin
      failures++;
      $display("FAIL drain_refill got v=%b d=%h id=%0d want v=1 d=%h id=1",
               out_valid, out_data, out_id, rot_ref(8'h5A, 5, 1'b1));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b01; out_ready = 1'b1;
    set_cmd(0, 8'hA5, 6, 1'b0);
    @(negedge clk);
    tick();
    req_valid = '0; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL rmid_pre got v=%b want v=1", out_valid);
    end
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_id !== 1'b0) begin
      failures++;
      $display("FAIL rmid_out got v=%b d=%h id=%0d want v=0 d=00 id=0", out_valid, out_data, out_id);
    end
    rst = 1'b0; out_ready = 1'b1;
    tick();
    req_valid = '1;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      failures++; $display("FAIL rmid_first_grant got=%b want=01", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic [NREQ-1:0] g;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          req_valid[i] = 1'b1;
          set_cmd(i, 8'($urandom), int'($urandom_range(0, 7)), 1'($urandom));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      checks++;
      if (req_ready !== exp_ready()) begin
        failures++; $display("FAIL rnd_ready[%0d] got=%b want=%b", c, req_ready, exp_ready());
      end
      checks++;
      if (out_valid !== m_ov || out_data !== m_data || out_id !== IDW'(m_id)) begin
        failures++;
        $display("FAIL rnd_out[%0d] got v=%b d=%h id=%0d want v=%b d=%h id=%0d",
                 c, out_valid, out_data, out_id, m_ov, m_data, m_id);
      end
      g = exp_ready();
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (g[i] && $urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
        else if (g[i]) set_cmd(i, 8'($urandom), int'($urandom_range(0, 7)), 1'($urandom));
      end
    end
    rst = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_num = '0; req_amt = '0; req_lr = '0; out_ready = 1'b0;
    test_reset();
    test_directed();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
